// File: rtl/fitbit_seven_seg_driver.sv
// fitbit_seven_seg_driver: double-dabble BCD conversion and 4-digit multiplexed seven-segment scan
module fitbit_seven_seg_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int MAX_SHOWN   = 9999
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] display,
    input  logic        is_miles,
    input  logic        SI,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [15:0] MAX_V = 16'(MAX_SHOWN);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_iter;
    logic [15:0]   r_val, r_scratch, r_bcd, w_adj;
    logic [1:0]    r_shadow, r_flag;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sel, w_sel;
    logic [3:0]    r_an, w_an, w_nib, w_blank;
    logic [6:0]    r_seg, w_seg, w_seg_dec;
    logic          r_dp, w_dp, w_wrap;
    logic [3:1]    w_zero;

    // conversion state register
    always_ff @(posedge CLK) begin
        r_state <= reset ? IDLE : w_next;
    end

    // conversion next state: one load, sixteen shifts, one commit
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   w_next = (r_iter == 4'd15) ? DONE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    // double-dabble correction: bump every nibble >= 5 before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < 4; k++)
            w_adj[k*4 +: 4] = (r_scratch[k*4 +: 4] >= 4'd5) ? r_scratch[k*4 +: 4] + 4'd3 : r_scratch[k*4 +: 4];
    end

    // conversion datapath; digits and flags commit together so they never mix samples
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_val     <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_shadow  <= '0;
            r_bcd     <= '0;
            r_flag    <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_val     <= (display > MAX_V) ? MAX_V : display;
                    r_shadow  <= {is_miles, SI};
                    r_scratch <= '0;
                    r_iter    <= '0;
                end
                SHIFT: begin
                    {r_scratch, r_val} <= {w_adj, r_val} << 1;
                    r_iter             <= r_iter + 4'd1;
                end
                DONE: begin
                    r_bcd  <= r_scratch;
                    r_flag <= r_shadow;
                end
                default: ;
            endcase
        end
    end

    assign w_wrap    = r_cnt == CW'(REFRESH_DIV - 1);
    assign w_sel     = r_sel + 2'd1;
    assign w_nib     = r_bcd[{w_sel, 2'b00} +: 4];
    assign w_zero[3] = r_bcd[15:12] == 4'd0;
    assign w_zero[2] = r_bcd[11:8] == 4'd0;
    assign w_zero[1] = r_bcd[7:4] == 4'd0;
    assign w_blank   = {w_zero[3], &w_zero[3:2], &w_zero[3:1], 1'b0};
    assign w_an      = ~(4'b0001 << w_sel);
    assign w_seg     = w_blank[w_sel] ? 7'b1111111 : w_seg_dec;
    assign w_dp      = ~((w_sel == 2'd0 && r_flag[1]) || (w_sel == 2'd3 && r_flag[0]));

    // digit decode for the slot about to be shown; unreachable codes blank
    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_nib)
            4'd0: w_seg_dec = 7'b1000000;
            4'd1: w_seg_dec = 7'b1111001;
            4'd2: w_seg_dec = 7'b0100100;
            4'd3: w_seg_dec = 7'b0110000;
            4'd4: w_seg_dec = 7'b0011001;
            4'd5: w_seg_dec = 7'b0010010;
            4'd6: w_seg_dec = 7'b0000010;
            4'd7: w_seg_dec = 7'b1111000;
            4'd8: w_seg_dec = 7'b0000000;
            4'd9: w_seg_dec = 7'b0010000;
            default: ;
        endcase
    end

    // refresh scan: advance digit and latch its drive only on the slot wrap
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt <= '0;
            r_sel <= '0;
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap) begin
                r_sel <= w_sel;
                r_an  <= w_an;
                r_seg <= w_seg;
                r_dp  <= w_dp;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;
endmodule

// File: tb/tb_fitbit_seven_seg_driver.sv
// tb_fitbit_seven_seg_driver: table vectors plus a cycle-level scoreboard of the scan outputs
module tb_fitbit_seven_seg_driver;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SB = 7'b1111111;

    typedef struct packed {
        logic [15:0] d;
        logic        m;
        logic        s;
        logic [27:0] sg;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] display = 16'd0;
    logic        is_miles = 1'b0;
    logic        SI = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int failures = 0;

    fitbit_seven_seg_driver #(.REFRESH_DIV(4), .MAX_SHOWN(9999)) dut (
        .CLK(CLK), .reset(reset), .display(display), .is_miles(is_miles), .SI(SI),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     nm, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
            5: return S5; 6: return S6; 7: return S7; 8: return S8; 9: return S9;
            default: return SB;
        endcase
    endfunction

    function automatic logic [11:0] exp_out(input int v, input logic [1:0] fl, input int k);
        int p;
        logic [6:0] s;
        logic [3:0] a;
        logic d;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        s = (k > 0 && v < p) ? SB : seg_of((v / p) % 10);
        a = ~(4'b0001 << k);
        d = !((k == 0 && fl[1]) || (k == 3 && fl[0]));
        return {a, s, d};
    endfunction

    // reference timing: capture every 19 cycles from cycle 2, commit 17 cycles later, slot wrap every 4
    int          m_cyc = 0;
    int          m_sel = 0;
    int          m_val = 0;
    int          m_bcd = 0;
    logic [1:0]  m_fl = 2'b00;
    logic [1:0]  m_flag = 2'b00;
    logic        m_live = 1'b0;
    logic [11:0] cur = 12'hfff;
    logic [11:0] q[$];

    always @(posedge CLK) begin
        if (reset) begin
            m_cyc  <= 0;
            m_sel  <= 0;
            m_val  <= 0;
            m_bcd  <= 0;
            m_fl   <= 2'b00;
            m_flag <= 2'b00;
            m_live <= 1'b1;
            q.push_back(12'hfff);
        end else if (m_live) begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % 4 == 0) begin
                q.push_back(exp_out(m_bcd, m_flag, (m_sel + 1) % 4));
                m_sel <= (m_sel + 1) % 4;
            end
            if (m_cyc + 1 >= 19 && (m_cyc + 1 - 19) % 19 == 0) begin
                m_bcd  <= m_val;
                m_flag <= m_fl;
            end
            if (m_cyc + 1 >= 2 && (m_cyc + 1 - 2) % 19 == 0) begin
                m_val <= (display > 16'd9999) ? 9999 : int'(display);
                m_fl  <= {is_miles, SI};
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            if (q.size() > 0) begin
                chk("scan_slot", {an, seg, dp}, q[0]);
                cur <= q.pop_front();
            end else begin
                chk("scan_hold", {an, seg, dp}, cur);
            end
        end
    end

    task automatic wait_until(input int n);
        while (m_cyc < n) @(negedge CLK);
    endtask

    task automatic check_slots(input logic [27:0] sg, input logic [1:0] fl, input string nm);
        int k;
        for (int i = 0; i < 4 && m_cyc % 4 != 0; i++) @(negedge CLK);
        for (int j = 0; j < 4; j++) begin
            k = (m_cyc / 4) % 4;
            chk($sformatf("%s_d%0d", nm, k), {an, seg, dp},
                {~(4'b0001 << k), sg[k*7 +: 7], ~((k == 0 && fl[1]) || (k == 3 && fl[0]))});
            repeat (4) @(negedge CLK);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        @(negedge CLK);
        display  = v.d;
        is_miles = v.m;
        SI       = v.s;
        repeat (40) @(negedge CLK);
        check_slots(v.sg, {v.m, v.s}, $sformatf("vec%0d", id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        vt[0]  = '{d: 16'd1234,  m: 1'b0, s: 1'b0, sg: {S1, S2, S3, S4}};
        vt[1]  = '{d: 16'd12000, m: 1'b0, s: 1'b1, sg: {S9, S9, S9, S9}};
        vt[2]  = '{d: 16'd7,     m: 1'b0, s: 1'b0, sg: {SB, SB, SB, S7}};
        vt[3]  = '{d: 16'd0,     m: 1'b1, s: 1'b0, sg: {SB, SB, SB, S0}};
        vt[4]  = '{d: 16'd1005,  m: 1'b0, s: 1'b0, sg: {S1, S0, S0, S5}};
        vt[5]  = '{d: 16'd42,    m: 1'b1, s: 1'b1, sg: {SB, SB, S4, S2}};
        vt[6]  = '{d: 16'd65535, m: 1'b1, s: 1'b0, sg: {S9, S9, S9, S9}};
        vt[7]  = '{d: 16'd10000, m: 1'b0, s: 1'b1, sg: {S9, S9, S9, S9}};
        vt[8]  = '{d: 16'd9999,  m: 1'b0, s: 1'b0, sg: {S9, S9, S9, S9}};
        vt[9]  = '{d: 16'd806,   m: 1'b1, s: 1'b1, sg: {SB, S8, S0, S6}};
        vt[10] = '{d: 16'd50,    m: 1'b0, s: 1'b0, sg: {SB, SB, S5, S0}};
        vt[11] = '{d: 16'd6,     m: 1'b0, s: 1'b1, sg: {SB, SB, SB, S6}};

        reset    = 1'b1;
        display  = 16'd1234;
        is_miles = 1'b0;
        SI       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset_hold", {an, seg, dp}, 12'hfff);
        end
        reset = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK);
            chk("pre_first_wrap", {an, seg, dp}, 12'hfff);
        end
        @(negedge CLK);
        chk("first_slot", {an, seg, dp}, {4'b1101, SB, 1'b1});

        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        @(negedge CLK);
        reset    = 1'b1;
        display  = 16'd42;
        is_miles = 1'b1;
        SI       = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        wait_until(26);
        display  = 16'd99;
        is_miles = 1'b0;
        wait_until(48);
        chk("coh_old_d0", {an, seg, dp}, {4'b1110, S2, 1'b0});
        wait_until(52);
        chk("coh_old_d1", {an, seg, dp}, {4'b1101, S4, 1'b1});
        wait_until(56);
        chk("coh_old_d2", {an, seg, dp}, {4'b1011, SB, 1'b1});
        wait_until(64);
        chk("coh_new_d0", {an, seg, dp}, {4'b1110, S9, 1'b1});
        wait_until(68);
        chk("coh_new_d1", {an, seg, dp}, {4'b1101, S9, 1'b1});

        wait_until(105);
        chk("pre_mid_reset", {an, seg, dp}, {4'b1011, SB, 1'b1});
        display  = 16'd4321;
        is_miles = 1'b0;
        SI       = 1'b0;
        reset    = 1'b1;
        @(negedge CLK);
        chk("mid_reset_blank", {an, seg, dp}, 12'hfff);
        reset = 1'b0;
        wait_until(20);
        check_slots({S4, S3, S2, S1}, 2'b00, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fitbit_seven_seg_driver.md
Name: fitbit_seven_seg_driver

Overview:
- Display back-end for the step tracker. Consumes the tracker's 16-bit `display` value and its `is_miles` and `SI` flags.
- Converts the value to 4-digit BCD with a sequential double-dabble engine.
- Time-multiplexes the digits onto a common-anode, active-low 4-digit seven-segment display, with leading-zero blanking and decimal-point indicators.

Parameters:
- REFRESH_DIV, 100000, CLK cycles per digit slot (1 kHz/digit at 100 MHz); minimum 2.
- MAX_SHOWN, 9999, saturation value for the displayed number.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- display  in  16  unsigned binary value from the tracker.
- is_miles  in  1  value is distance; lights the unit dot.
- SI  in  1  tracker saturation flag; lights the saturation dot.
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (reset=1 at a CLK edge), next cycle:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - bcd_reg=16'h0000, flag_reg=2'b00.
  - digit_sel=0, refresh_cnt=0, FSM=IDLE.
  - Reset overrides everything, including a conversion in progress; the partial result is discarded.
- Conversion FSM (runs continuously):
  - IDLE -> LOAD, unconditionally, 1 cycle.
  - LOAD:
    - Capture val = (display > MAX_SHOWN) ? MAX_SHOWN : display.
    - Capture {is_miles, SI} into a shadow register.
    - Clear scratch BCD; iter=0.
  - SHIFT, 16 cycles (iter 0..15). Each cycle:
    - Add 3 to every scratch BCD nibble >= 5.
    - Then shift {bcd, val} left by 1.
    - Go to DONE when iter==15.
  - DONE:
    - bcd_reg <= scratch BCD; flag_reg <= shadow flags.
    - Go to IDLE.
  - Timing: capture-to-update latency is 18 cycles; full period is 19 cycles.
  - Inputs are sampled only in LOAD. Changes during SHIFT/DONE take effect at the next LOAD.
  - bcd_reg and flag_reg update atomically, so a digit and its dot always come from the same sample.
- Refresh scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On the wrap cycle, digit_sel <= digit_sel+1 (mod 4).
  - On the same edge, an/seg/dp are registered from the new digit_sel and the current bcd_reg/flag_reg.
  - Between wraps an/seg/dp hold constant, even if bcd_reg changes.
  - After reset the outputs stay blank until the first wrap (REFRESH_DIV cycles); the first lit digit is digit_sel=1.
  - an is one-hot low: digit k -> an[k]=0, others 1.
- Digit encoding, seg:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble >9 (not reachable) maps to blank 1111111.
- Leading-zero blanking:
  - Digit k (k=3..1) shows blank seg=1111111 if it and all higher digits are 0.
  - Digit 0 always shows its value, so 0 displays as "0".
  - The anode is still driven low for a blanked digit.
- Decimal point (dp=0 means lit):
  - Lit when digit_sel=0 and flag_reg.is_miles=1.
  - Lit when digit_sel=3 and flag_reg.SI=1.
  - Otherwise dp=1.
  - A blanked digit 3 still shows the SI dot.
- Arithmetic: all conversion arithmetic is unsigned. Scratch is 16 BCD bits plus 16 binary bits; no overflow is possible, since val is at most 9999.

Test Plan:
- Reset: hold reset 3 cycles with display=16'h1234 -> an=1111, seg=1111111, dp=1 during reset and until the first refresh wrap.
- Conversion and scan, REFRESH_DIV=4, display=1234:
  - bcd_reg=16'h1234 within 18 cycles of LOAD.
  - Successive scan slots: an=1110/seg=0011001 ("4"), an=1101/seg=0110000 ("3"), an=1011/seg=0100100 ("2"), an=0111/seg=1111001 ("1").
- Saturation: display=12000 with SI=1 -> all digits "9" (0010000); dp=0 only in the an=0111 slot.
- Blanking:
  - display=7 -> digits 3..1 seg=1111111 and digit 0 seg=1111000.
  - display=0 -> digit 0 seg=1000000, others blank.
  - display=1005 -> digits show 1,0,0,5, with no blanking of the inner zeros.
- Flag coherence: is_miles=1 with display=42, then toggle is_miles and display=99 mid-SHIFT -> the old pair (42, dot on an=1110) stays until DONE of the next conversion, then the new pair appears together.
- Reset mid-operation: assert reset during SHIFT iter 8 while an=1011 -> next cycle outputs blank and digit_sel=0; after release, the first conversion yields the current display value exactly.
